// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: entry layout {float, addr, data},
// GPR zero address and source-select encoding.
package wb_arbiter_pkg;

    localparam int         WB_ENTRY_W = 38;
    localparam logic [4:0] GPR_ZERO   = 5'd0;

    typedef struct packed {
        logic        flt;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_ALU  = 2'd3
    } wb_src_e;

    // GPR r0 is hardwired; writes to it are meaningless. FPR f0 is a real register.
    function automatic logic is_gpr_zero(input logic flt, input logic [4:0] addr);
        return !flt && (addr == GPR_ZERO);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the ALU/memory stages, the register-file write port and the
// forwarding query port of wb_arbiter.
interface wb_arbiter_if;
    logic        alu_enable;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_float;
    logic        mem_enable;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_float;
    logic        alu_stall;
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_float;
    logic        overflow;
    logic [4:0]  q_addr;
    logic        q_float;
    logic        q_hit;
    logic [31:0] q_data;

    modport master (
        output alu_enable, alu_addr, alu_data, alu_float,
        output mem_enable, mem_addr, mem_data, mem_float,
        output q_addr, q_float,
        input  alu_stall, wb_enable, wb_addr, wb_data, wb_float, overflow,
        input  q_hit, q_data
    );

    modport slave (
        input  alu_enable, alu_addr, alu_data, alu_float,
        input  mem_enable, mem_addr, mem_data, mem_float,
        input  q_addr, q_float,
        output alu_stall, wb_enable, wb_addr, wb_data, wb_float, overflow,
        output q_hit, q_data
    );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// In-order holding FIFO for deferred ALU results; also presents its contents
// oldest-to-youngest so the parent can scan them for forwarding.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  wb_entry_t        din_i,
    output wb_entry_t        head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output wb_entry_t        ent_o [DEPTH],
    output logic [DEPTH-1:0] vld_o
);

    logic [WB_ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]         rptr_q, wptr_q;
    logic [CW-1:0]         count_q;
    logic                  pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = wb_entry_t'(mem_q[rptr_q]);

    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_o[i] = wb_entry_t'(mem_q[rptr_q + AW'(i)]);
            vld_o[i] = (CW'(i) < count_q);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges load results and ALU results onto one register-file write port.
// Optional macro WB_FWD_EN enables the forwarding query against pending ALU results.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int STALL_LVL = 3
) (
    input logic         clk,
    input logic         reset,
    wb_arbiter_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t        alu_ent, mem_ent, head_ent, sel_ent;
    wb_entry_t        fwd_ent [DEPTH];
    logic [DEPTH-1:0] fwd_vld;
    logic             alu_vld, mem_vld;
    logic             push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count, count_nxt;
    wb_src_e          sel;

    wb_entry_t wb_q, wb_d;
    logic      wb_en_q, wb_en_d;
    logic      stall_q, stall_d;
    logic      ovf_q, ovf_d;
    logic        q_hit;
    logic [31:0] q_data;

    assign alu_ent = '{flt: bus.alu_float, addr: bus.alu_addr, data: bus.alu_data};
    assign mem_ent = '{flt: bus.mem_float, addr: bus.mem_addr, data: bus.mem_data};
    assign alu_vld = bus.alu_enable && !is_gpr_zero(bus.alu_float, bus.alu_addr);
    assign mem_vld = bus.mem_enable && !is_gpr_zero(bus.mem_float, bus.mem_addr);

    // Loads are never stalled, so they always win; queued ALU results go before new ones.
    always_comb begin
        sel     = SRC_NONE;
        sel_ent = wb_q;
        if (mem_vld) begin
            sel     = SRC_MEM;
            sel_ent = mem_ent;
        end else if (!fifo_empty) begin
            sel     = SRC_FIFO;
            sel_ent = head_ent;
        end else if (alu_vld) begin
            sel     = SRC_ALU;
            sel_ent = alu_ent;
        end
    end

    assign push_req  = alu_vld && (sel != SRC_ALU);
    assign fifo_pop  = (sel == SRC_FIFO);
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (alu_ent),
        .head_o  (head_ent),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .ent_o   (fwd_ent),
        .vld_o   (fwd_vld)
    );

    always_comb begin
        wb_en_d = (sel != SRC_NONE);
        wb_d    = sel_ent;
        stall_d = (count_nxt >= CW'(STALL_LVL));
        ovf_d   = ovf_q | (push_req && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_q    <= '0;
            wb_en_q <= 1'b0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wb_q    <= wb_d;
            wb_en_q <= wb_en_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the last match is the most recent value.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fwd_vld[i] && (fwd_ent[i].addr == bus.q_addr) && (fwd_ent[i].flt == bus.q_float)
                && !is_gpr_zero(bus.q_float, bus.q_addr)) begin
                q_hit  = 1'b1;
                q_data = fwd_ent[i].data;
            end
        end
    end
`else
    logic unused_fwd;
    always_comb begin
        unused_fwd = ^{bus.q_addr, bus.q_float, fwd_vld};
        for (int i = 0; i < DEPTH; i++) unused_fwd = unused_fwd ^ (^fwd_ent[i]);
    end
    assign q_hit  = 1'b0;
    assign q_data = '0;
`endif

    assign bus.wb_enable = wb_en_q;
    assign bus.wb_addr   = wb_q.addr;
    assign bus.wb_data   = wb_q.data;
    assign bus.wb_float  = wb_q.flt;
    assign bus.alu_stall = stall_q;
    assign bus.overflow  = ovf_q;
    assign bus.q_hit     = q_hit;
    assign bus.q_data    = q_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes go to a scoreboard queue
// and are matched in order by a monitor; timing, stall, overflow and forwarding are checked inline.
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    logic [37:0] sb [$];

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(4), .STALL_LVL(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_enable = 1'b0; bus.alu_addr = '0; bus.alu_data = '0; bus.alu_float = 1'b0;
        bus.mem_enable = 1'b0; bus.mem_addr = '0; bus.mem_data = '0; bus.mem_float = 1'b0;
        bus.q_addr = '0; bus.q_float = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] a, input logic [31:0] d, input logic f);
        bus.alu_enable = 1'b1; bus.alu_addr = a; bus.alu_data = d; bus.alu_float = f;
    endtask

    task automatic drive_mem(input logic [4:0] a, input logic [31:0] d, input logic f);
        bus.mem_enable = 1'b1; bus.mem_addr = a; bus.mem_data = d; bus.mem_float = f;
    endtask

    task automatic randomize_inputs();
        bus.alu_enable = 1'($urandom_range(0, 1)); bus.alu_addr = 5'($urandom);
        bus.alu_data   = $urandom;                 bus.alu_float = 1'($urandom_range(0, 1));
        bus.mem_enable = 1'($urandom_range(0, 1)); bus.mem_addr = 5'($urandom);
        bus.mem_data   = $urandom;                 bus.mem_float = 1'($urandom_range(0, 1));
        bus.q_addr     = 5'($urandom);             bus.q_float  = 1'($urandom_range(0, 1));
    endtask

    // Every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.wb_enable === 1'b1) begin
            n_chk++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL wb_unexpected observed=0x%0h expected=none",
                       {bus.wb_float, bus.wb_addr, bus.wb_data});
            end
            if (sb.size() != 0) begin
                logic [37:0] e;
                e = sb.pop_front();
                chk("wb_write", 64'({bus.wb_float, bus.wb_addr, bus.wb_data}), 64'(e));
            end
        end
    end

    initial begin
        logic exp_hit;
        logic [31:0] exp_qd;

        // 1: reset with random inputs
        reset = 1'b0;
        randomize_inputs();
        step();
        randomize_inputs();
        step();
        idle();
        #1;
        chk("rst_wb_enable", 64'(bus.wb_enable), 64'd0);
        chk("rst_wb_addr",   64'(bus.wb_addr),   64'd0);
        chk("rst_wb_data",   64'(bus.wb_data),   64'd0);
        chk("rst_wb_float",  64'(bus.wb_float),  64'd0);
        chk("rst_alu_stall", 64'(bus.alu_stall), 64'd0);
        chk("rst_overflow",  64'(bus.overflow),  64'd0);
        chk("rst_q_hit",     64'(bus.q_hit),     64'd0);
        chk("rst_q_data",    64'(bus.q_data),    64'd0);
        reset = 1'b1;
        step();
        step();
        chk("rst_fifo_empty", 64'(bus.wb_enable), 64'd0);

        // 2: direct ALU path, latency 1
        drive_alu(5'd5, 32'h1234, 1'b0);
        sb.push_back({1'b0, 5'd5, 32'h1234});
        step();
        chk("alu_direct_en", 64'(bus.wb_enable), 64'd1);
        idle();
        step();
        chk("alu_direct_noq", 64'(bus.wb_enable), 64'd0);

        // 3: collision, load first then queued ALU
        drive_alu(5'd3, 32'hA, 1'b0);
        drive_mem(5'd7, 32'hB, 1'b1);
        sb.push_back({1'b1, 5'd7, 32'hB});
        sb.push_back({1'b0, 5'd3, 32'hA});
        step();
        chk("coll_c1_en",    64'(bus.wb_enable), 64'd1);
        chk("coll_c1_float", 64'(bus.wb_float),  64'd1);
        idle();
        step();
        chk("coll_c2_en",    64'(bus.wb_enable), 64'd1);
        chk("coll_c2_float", 64'(bus.wb_float),  64'd0);
        step();
        chk("coll_c3_en",    64'(bus.wb_enable), 64'd0);
        chk("coll_hold_addr", 64'(bus.wb_addr),  64'd3);
        chk("coll_hold_data", 64'(bus.wb_data),  64'hA);

        // 4: GPR r0 filtered, FPR f0 written
        drive_alu(5'd0, 32'hDEAD, 1'b0);
        step();
        chk("gpr0_filtered", 64'(bus.wb_enable), 64'd0);
        drive_alu(5'd0, 32'h3F80_0000, 1'b1);
        sb.push_back({1'b1, 5'd0, 32'h3F80_0000});
        step();
        chk("fpr0_written", 64'(bus.wb_enable), 64'd1);
        idle();
        step();

        // 5: loads every cycle, ALU results pile up, stall and overflow
        for (int k = 1; k <= 5; k++) begin
            drive_mem(5'(10 + k), 32'h100 + 32'(k), 1'b0);
            drive_alu(5'(20 + k), 32'hA0 + 32'(k), 1'b0);
            sb.push_back({1'b0, 5'(10 + k), 32'h100 + 32'(k)});
            step();
            chk($sformatf("fill_stall_%0d", k),    64'(bus.alu_stall), 64'(k >= 3));
            chk($sformatf("fill_overflow_%0d", k), 64'(bus.overflow),  64'(k >= 5));
        end
        idle();
        for (int k = 1; k <= 4; k++) sb.push_back({1'b0, 5'(20 + k), 32'hA0 + 32'(k)});
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("drain_en_%0d", k),    64'(bus.wb_enable), 64'd1);
            chk($sformatf("drain_stall_%0d", k), 64'(bus.alu_stall), 64'(k == 1));
        end
        step();
        chk("drain_done", 64'(bus.wb_enable), 64'd0);
        chk("overflow_sticky", 64'(bus.overflow), 64'd1);

        // 6: forwarding query over pending ALU results
        drive_mem(5'd1, 32'h51, 1'b0);
        drive_alu(5'd9, 32'h11, 1'b0);
        sb.push_back({1'b0, 5'd1, 32'h51});
        step();
        drive_mem(5'd2, 32'h52, 1'b0);
        drive_alu(5'd9, 32'h22, 1'b0);
        sb.push_back({1'b0, 5'd2, 32'h52});
        step();
        bus.alu_enable = 1'b0;
        drive_mem(5'd3, 32'h53, 1'b0);
        sb.push_back({1'b0, 5'd3, 32'h53});
        bus.q_addr = 5'd9;
        bus.q_float = 1'b0;
        #1;
`ifdef WB_FWD_EN
        exp_hit = 1'b1;
        exp_qd  = 32'h22;
`else
        exp_hit = 1'b0;
        exp_qd  = 32'h0;
`endif
        chk("fwd_gpr_hit",  64'(bus.q_hit),  64'(exp_hit));
        chk("fwd_gpr_data", 64'(bus.q_data), 64'(exp_qd));
        bus.q_float = 1'b1;
        #1;
        chk("fwd_fpr_hit",  64'(bus.q_hit),  64'd0);
        chk("fwd_fpr_data", 64'(bus.q_data), 64'd0);
        step();

        // 7: reset while two ALU results are pending
        reset = 1'b0;
        drive_mem(5'd4, 32'h54, 1'b0);
        drive_alu(5'd12, 32'h77, 1'b0);
        step();
        chk("midrst_wb_en",    64'(bus.wb_enable), 64'd0);
        chk("midrst_overflow", 64'(bus.overflow),  64'd0);
        chk("midrst_stall",    64'(bus.alu_stall), 64'd0);
        reset = 1'b1;
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("midrst_idle_%0d", k), 64'(bus.wb_enable), 64'd0);
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
